// File: rtl/mod_arb_pkg.sv
// Shared types for the modular-remainder arbiter: FSM state encoding and
// the requester-index width helper.
package mod_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  // A single requester still needs a one-bit index field.
  function automatic int id_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/mod_rr_pick.sv
// Combinational round-robin picker: searches upward from last_grant+1 with
// wrap and returns the first asserted request as one-hot and binary index.
module mod_rr_pick
  import mod_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               any_req
);

  logic [ID_W-1:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_req   = 1'b0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(last_grant) + k) % NUM_REQ);
      if (!any_req && req[cand]) begin
        any_req         = 1'b1;
        grant[cand]     = 1'b1;
        grant_idx       = cand;
      end
    end
  end

endmodule

// File: rtl/novel_mod_operator.sv
// Sequential unsigned remainder unit (A mod B), one restoring step per cycle.
// start is taken only while idle; done pulses for one cycle with result valid.
module novel_mod_operator #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         done,
  output logic [N-1:0] result
);

  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  logic             running;
  logic [CNT_W-1:0] cnt;
  logic [N-1:0]     dvd;
  logic [N-1:0]     dvs;
  logic [N-1:0]     rem;
  logic [N:0]       trial;
  logic [N-1:0]     rem_next;

  // rem stays below the divisor, so the shifted trial value needs one extra
  // bit and the restored remainder always fits back into N bits.
  always_comb begin
    trial = {rem, dvd[N-1]};
    if (trial >= {1'b0, dvs}) begin
      rem_next = N'(trial - {1'b0, dvs});
    end else begin
      rem_next = trial[N-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      running <= 1'b0;
      cnt     <= '0;
      dvd     <= '0;
      dvs     <= '0;
      rem     <= '0;
      done    <= 1'b0;
      result  <= '0;
    end else begin
      done <= 1'b0;
      if (!running) begin
        if (start) begin
          running <= 1'b1;
          dvd     <= a;
          dvs     <= b;
          rem     <= '0;
          cnt     <= CNT_W'(N - 1);
        end
      end else begin
        rem <= rem_next;
        dvd <= {dvd[N-2:0], 1'b0};
        if (cnt == '0) begin
          running <= 1'b0;
          done    <= 1'b1;
          result  <= rem_next;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mod_arbiter.sv
// Round-robin front end sharing one remainder unit among NUM_REQ requesters,
// with a tagged response channel and local trapping of zero divisors.
module mod_arbiter
  import mod_arb_pkg::*;
#(
  parameter int N       = 32,
  parameter int NUM_REQ = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*N-1:0]       req_a,
  input  logic [NUM_REQ*N-1:0]       req_b,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [$clog2(NUM_REQ)-1:0] resp_id,
  output logic [N-1:0]               resp_result,
  output logic                       resp_err,
  output logic                       busy
);

  localparam int ID_W = id_width(NUM_REQ);

  state_t          state;
  logic [ID_W-1:0] last_grant;
  logic [ID_W-1:0] op_id;
  logic [N-1:0]    op_a;
  logic [N-1:0]    op_b;

  logic [NUM_REQ-1:0] pick_grant;
  logic [ID_W-1:0]    pick_idx;
  logic               pick_any;
  logic [N-1:0]       sel_a;
  logic [N-1:0]       sel_b;

  logic               unit_start;
  logic               unit_done;
  logic [N-1:0]       unit_result;

  mod_rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_pick (
    .req       (req_valid),
    .last_grant(last_grant),
    .grant     (pick_grant),
    .grant_idx (pick_idx),
    .any_req   (pick_any)
  );

  assign sel_a = req_a[int'(pick_idx)*N +: N];
  assign sel_b = req_b[int'(pick_idx)*N +: N];

  // Grants are only offered from IDLE and are suppressed while reset is held.
  assign req_ready  = (state == IDLE && !rst) ? pick_grant : '0;
  assign unit_start = (state == ISSUE);
  assign resp_valid = (state == RESP);
  assign busy       = (state != IDLE);

  novel_mod_operator #(
    .N(N)
  ) u_mod (
    .clk   (clk),
    .rst   (rst),
    .start (unit_start),
    .a     (op_a),
    .b     (op_b),
    .done  (unit_done),
    .result(unit_result)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      last_grant  <= ID_W'(NUM_REQ - 1);
      op_id       <= '0;
      op_a        <= '0;
      op_b        <= '0;
      resp_id     <= '0;
      resp_result <= '0;
      resp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            op_id      <= pick_idx;
            op_a       <= sel_a;
            op_b       <= sel_b;
            last_grant <= pick_idx;
            // A zero divisor never reaches the unit; answer with A directly.
            if (sel_b == '0) begin
              resp_id     <= pick_idx;
              resp_result <= sel_a;
              resp_err    <= 1'b1;
              state       <= RESP;
            end else begin
              state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          state <= WAIT;
        end
        WAIT: begin
          if (unit_done) begin
            resp_id     <= op_id;
            resp_result <= unit_result;
            resp_err    <= 1'b0;
            state       <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mod_arbiter.sv
// Scoreboard bench for mod_arbiter: a round-robin reference model predicts the
// response stream; a monitor pops and compares each accepted response.
module tb_mod_arbiter;

  localparam int N       = 32;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
  } op_t;

  typedef struct {
    int           id;
    logic [N-1:0] result;
    logic         err;
  } exp_t;

  logic                 clk;
  logic                 rst;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ*N-1:0] req_a;
  logic [NUM_REQ*N-1:0] req_b;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [ID_W-1:0]      resp_id;
  logic [N-1:0]         resp_result;
  logic                 resp_err;
  logic                 busy;

  op_t  opq[NUM_REQ][$];
  exp_t exp_q[$];

  int vectors     = 0;
  int miscompares = 0;
  int mdl_last    = NUM_REQ - 1;
  int start_count = 0;
  int rr_mode     = 0;

  mod_arbiter #(
    .N      (N),
    .NUM_REQ(NUM_REQ)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_result(resp_result),
    .resp_err   (resp_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic exp_t refModel(input int id, input op_t op);
    exp_t e;
    e.id     = id;
    e.err    = (op.b == 0);
    e.result = e.err ? op.a : (op.a % op.b);
    return e;
  endfunction

  task automatic presentOp(input int i, input int pos);
    if (pos < opq[i].size()) begin
      req_valid[i]       = 1'b1;
      req_a[i*N +: N]    = opq[i][pos].a;
      req_b[i*N +: N]    = opq[i][pos].b;
    end else begin
      req_valid[i] = 1'b0;
    end
  endtask

  // Loads the expected responses for everything queued in opq, then plays the
  // requesters until every operation is accepted and answered.
  task automatic applyStimulus(input string tag);
    int pos[NUM_REQ];
    int total;
    int ptr;
    int budget;
    logic [NUM_REQ-1:0] acc;
    op_t op;
    total = 0;
    ptr   = mdl_last;
    for (int i = 0; i < NUM_REQ; i++) begin
      pos[i] = 0;
      total += opq[i].size();
    end
    for (int n = 0; n < total; n++) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        int c;
        c = (ptr + k) % NUM_REQ;
        if (pos[c] < opq[c].size()) begin
          exp_q.push_back(refModel(c, opq[c][pos[c]]));
          pos[c]++;
          ptr = c;
          break;
        end
      end
    end
    mdl_last = ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      pos[i] = 0;
      presentOp(i, 0);
    end
    budget = 200 * total + 200;
    while (req_valid != '0 && budget > 0) begin
      #1;
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (acc[i]) begin
          op = opq[i][pos[i]];
          if (op.b == 0) begin
            checkOutput({tag, " zero_div_resp_next_cycle"}, resp_valid, 1);
            checkOutput({tag, " zero_div_no_start"}, dut.unit_start, 0);
          end else begin
            checkOutput({tag, " start_after_accept"}, dut.unit_start, 1);
            checkOutput({tag, " no_early_resp"}, resp_valid, 0);
          end
          pos[i]++;
          presentOp(i, pos[i]);
        end
      end
      budget--;
    end
    checkOutput({tag, " all_accepted"}, req_valid, 0);
    while (exp_q.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    checkOutput({tag, " all_answered"}, exp_q.size(), 0);
    req_valid = '0;
    exp_q.delete();
    for (int i = 0; i < NUM_REQ; i++) opq[i].delete();
    repeat (2) @(negedge clk);
  endtask

  // Scoreboard monitor plus frozen-output and no-grant checks while stalled.
  logic            held_valid = 1'b0;
  logic [ID_W-1:0] held_id;
  logic [N-1:0]    held_result;
  logic            held_err;
  exp_t            mon_exp;

  always @(negedge clk) begin
    if (rst) begin
      held_valid = 1'b0;
    end else begin
      if (dut.unit_start) start_count++;
      if (held_valid) begin
        checkOutput("stall_valid_held", resp_valid, 1);
        checkOutput("stall_id_frozen", resp_id, held_id);
        checkOutput("stall_result_frozen", resp_result, held_result);
        checkOutput("stall_err_frozen", resp_err, held_err);
      end
      if (resp_valid) checkOutput("no_grant_in_resp", req_ready, 0);
      if (resp_valid && resp_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_resp", resp_valid, 0);
        end else begin
          mon_exp = exp_q.pop_front();
          checkOutput("resp_id", resp_id, mon_exp.id);
          checkOutput("resp_result", resp_result, mon_exp.result);
          checkOutput("resp_err", resp_err, mon_exp.err);
        end
      end
      held_valid  = resp_valid && !resp_ready;
      held_id     = resp_id;
      held_result = resp_result;
      held_err    = resp_err;
    end
  end

  initial begin
    resp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rr_mode)
        1:       resp_ready = ($urandom_range(0, 3) != 0);
        2:       resp_ready = 1'b0;
        default: resp_ready = 1'b1;
      endcase
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL global_timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " req_ready"}, req_ready, 0);
    checkOutput({tag, " resp_valid"}, resp_valid, 0);
    checkOutput({tag, " resp_id"}, resp_id, 0);
    checkOutput({tag, " resp_result"}, resp_result, 0);
    checkOutput({tag, " resp_err"}, resp_err, 0);
    checkOutput({tag, " busy"}, busy, 0);
  endtask

  initial begin
    int budget;
    int seen;
    op_t op;
    rst       = 1'b1;
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;
    #3;
    checkResetValues("reset");
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idle_after_reset", busy, 0);

    // Fairness: grant order 0,1,2,3,0,1 with all requesters loaded.
    opq[0].push_back('{a: 32'd1001, b: 32'd10});
    opq[0].push_back('{a: 32'd999,  b: 32'd17});
    opq[1].push_back('{a: 32'd500,  b: 32'd7});
    opq[1].push_back('{a: 32'd12345, b: 32'd100});
    opq[2].push_back('{a: 32'd77,   b: 32'd0});
    opq[3].push_back('{a: 32'd65536, b: 32'd255});
    applyStimulus("fairness");

    begin
      int s;
      s = start_count;
      opq[0].push_back('{a: 32'd100, b: 32'd7});
      applyStimulus("basic");
      checkOutput("basic_start_pulses", start_count - s, 1);
      s = start_count;
      opq[1].push_back('{a: 32'd55, b: 32'd0});
      applyStimulus("div_zero");
      checkOutput("div_zero_start_pulses", start_count - s, 0);
    end

    // Backpressure: response held for 10 cycles while req3 waits.
    rr_mode = 2;
    opq[0].push_back('{a: 32'd1234, b: 32'd10});
    opq[3].push_back('{a: 32'd77, b: 32'd5});
    fork
      applyStimulus("backpressure");
      begin
        budget = 200;
        while (!resp_valid && budget > 0) begin
          @(negedge clk);
          budget--;
        end
        checkOutput("bp_resp_seen", resp_valid, 1);
        repeat (10) begin
          @(negedge clk);
          checkOutput("bp_ready_low", req_ready, 0);
          checkOutput("bp_valid_held", resp_valid, 1);
        end
        rr_mode = 0;
      end
    join

    opq[0].push_back('{a: 32'd5, b: 32'd9});
    opq[1].push_back('{a: 32'hFFFF_FFFF, b: 32'd1});
    opq[2].push_back('{a: 32'hFFFF_FFFF, b: 32'h8000_0000});
    opq[3].push_back('{a: 32'd0, b: 32'd13});
    applyStimulus("edge");

    // Reset during WAIT discards the operation without a response.
    req_a[0*N +: N] = 32'd1000;
    req_b[0*N +: N] = 32'd3;
    req_valid[0]    = 1'b1;
    budget = 50;
    while (budget > 0) begin
      #1;
      if (req_ready[0]) break;
      @(posedge clk);
      budget--;
    end
    checkOutput("midwait_accept", req_ready[0], 1);
    @(posedge clk);
    #1;
    req_valid = '0;
    repeat (5) @(posedge clk);
    #2;
    checkOutput("midwait_busy", busy, 1);
    rst = 1'b1;
    #1;
    checkResetValues("midwait_reset");
    @(negedge clk);
    rst      = 1'b0;
    mdl_last = NUM_REQ - 1;
    seen     = 0;
    repeat (50) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    checkOutput("midwait_no_resp", seen, 0);
    opq[2].push_back('{a: 32'd1000, b: 32'd3});
    applyStimulus("post_reset");

    // Randomised batches with random response backpressure.
    rr_mode = 1;
    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        int cnt;
        cnt = $urandom_range(0, 2);
        for (int j = 0; j < cnt; j++) begin
          case ($urandom_range(0, 7))
            0:       op.b = 32'd0;
            1:       op.b = 32'd1;
            2, 3, 4: op.b = 32'($urandom_range(1, 20));
            default: op.b = $urandom;
          endcase
          op.a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 50)) : $urandom;
          opq[i].push_back(op);
        end
      end
      applyStimulus("random");
    end
    rr_mode = 0;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
